// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : EX/MEM pipeline register. Carries write-back, HI/LO and memory
//             fields from EX to MEM, honours the stall vector, supports a
//             synchronous flush and holds EX multi-cycle temporaries.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 5,
  parameter int ALUOP_W   = 8,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,           // asynchronous, active-low
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic [RADDR_W-1:0]   ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic                 ex_whilo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic [2*DATA_W-1:0]  hilo_temp_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic                 mem_valid,
  output logic [RADDR_W-1:0]   mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic                 mem_whilo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic [2*DATA_W-1:0]  hilo_temp_o,
  output logic [CNT_W-1:0]     cnt_o
);

  logic                 r_valid;
  logic [RADDR_W-1:0]   r_wd;
  logic                 r_wreg;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;
  logic                 r_whilo;
  logic [ALUOP_W-1:0]   r_aluop;
  logic [DATA_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_reg2;
  logic [2*DATA_W-1:0]  r_hilo_temp;
  logic [CNT_W-1:0]     r_cnt;

  logic w_es;   // EX stage stalled
  logic w_ms;   // MEM stage stalled

  assign w_es = stall[STAGE_IDX];
  assign w_ms = stall[STAGE_IDX+1];

  // Pipeline register: flush > bubble > hold > advance. EX stalled alone
  // inserts a bubble while capturing the in-flight multi-cycle temporary;
  // EX stalled with MEM stalled freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_whilo     <= 1'b0;
      r_aluop     <= '0;
      r_mem_addr  <= '0;
      r_reg2      <= '0;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_whilo     <= 1'b0;
      r_aluop     <= '0;
      r_mem_addr  <= '0;
      r_reg2      <= '0;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (w_es && !w_ms) begin
      r_valid     <= 1'b0;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_whilo     <= 1'b0;
      r_aluop     <= '0;
      r_mem_addr  <= '0;
      r_reg2      <= '0;
      r_hilo_temp <= hilo_temp_i;
      r_cnt       <= cnt_i;
    end else if (!w_es) begin
      // An illegal es=0/ms=1 combination also lands here and advances.
      r_valid     <= ex_valid;
      r_wd        <= ex_wd;
      r_wreg      <= ex_wreg;
      r_wdata     <= ex_wdata;
      r_hi        <= ex_hi;
      r_lo        <= ex_lo;
      r_whilo     <= ex_whilo;
      r_aluop     <= ex_aluop;
      r_mem_addr  <= ex_mem_addr;
      r_reg2      <= ex_reg2;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end
    // es=1, ms=1: every register keeps its value.
  end

  assign mem_valid    = r_valid;
  assign mem_wd       = r_wd;
  assign mem_wreg     = r_wreg;
  assign mem_wdata    = r_wdata;
  assign mem_hi       = r_hi;
  assign mem_lo       = r_lo;
  assign mem_whilo    = r_whilo;
  assign mem_aluop    = r_aluop;
  assign mem_mem_addr = r_mem_addr;
  assign mem_reg2     = r_reg2;
  assign hilo_temp_o  = r_hilo_temp;
  assign cnt_o        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Scoreboard bench for ex_mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo_temp;
    logic [1:0]  cnt;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  bundle_t     in_b = '0;

  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks   = 0;
  int failures = 0;

  bundle_t model = '0;
  bundle_t exp_q[$];
  bundle_t got, exp_v;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(in_b.valid), .ex_wd(in_b.wd), .ex_wreg(in_b.wreg),
    .ex_wdata(in_b.wdata), .ex_hi(in_b.hi), .ex_lo(in_b.lo),
    .ex_whilo(in_b.whilo), .ex_aluop(in_b.aluop),
    .ex_mem_addr(in_b.addr), .ex_reg2(in_b.reg2),
    .hilo_temp_i(in_b.hilo_temp), .cnt_i(in_b.cnt),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  // Stalls propagate upstream: MEM stalled with EX running is illegal.
  assert property (@(posedge clk) disable iff (!rst) !(!stall[3] && stall[4]))
    else $error("stall contract violated");

  function automatic bundle_t dut_out();
    bundle_t b;
    b = '{mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
          mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o};
    return b;
  endfunction

  // Reference behaviour of one clock edge.
  function automatic bundle_t model_next(bundle_t cur, logic fl, logic [5:0] st, bundle_t x);
    bundle_t r;
    if (fl) r = '0;
    else if (st[3] && !st[4]) begin
      r = '0;
      r.hilo_temp = x.hilo_temp;
      r.cnt = x.cnt;
    end else if (st[3]) r = cur;
    else begin
      r = x;
      r.hilo_temp = '0;
      r.cnt = '0;
    end
    return r;
  endfunction

  function automatic bundle_t rnd_in();
    bundle_t b;
    b = '{1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          1'($urandom), 8'($urandom), $urandom, $urandom,
          {$urandom, $urandom}, 2'($urandom)};
    return b;
  endfunction

  // Drive one cycle of stimulus, push the predicted outputs, sample after the edge.
  task automatic apply(input bundle_t x, input logic [5:0] st, input logic fl);
    in_b  = x;
    stall = st;
    flush = fl;
    model = model_next(model, fl, st, x);
    exp_q.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_hold();
    bundle_t x;
    checks++;
    if (dut_out() !== bundle_t'(0)) begin
      failures++; $display("FAIL reset_state got=%h exp=0", dut_out());
    end
    @(negedge clk); rst = 1'b1; model = '0;
    x = '0; x.valid = 1'b1; x.wreg = 1'b1; x.wdata = 32'h12345678;
    apply(x, 6'b000000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_load got=%h exp=%h", got, exp_v); end
    apply(rnd_in(), 6'b011000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || mem_wdata !== 32'h12345678) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", got, exp_v);
    end
    #2 rst = 1'b0;
    #1;
    model = '0; checks++;
    if (dut_out() !== bundle_t'(0)) begin
      failures++; $display("FAIL reset_async got=%h exp=0", dut_out());
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_advance();
    bundle_t x;
    x = rnd_in(); x.valid = 1'b1; x.wd = 5'd5; x.wdata = 32'hDEADBEEF;
    x.whilo = 1'b1; x.hi = 32'h1; x.lo = 32'h2;
    apply(x, 6'b000000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || mem_wd !== 5'd5 || mem_wdata !== 32'hDEADBEEF || mem_valid !== 1'b1) begin
      failures++; $display("FAIL advance got=%h exp=%h", got, exp_v);
    end
    x = rnd_in(); x.valid = 1'b0;
    apply(x, 6'b000000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL advance_invalid got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_bubble_temps();
    bundle_t x;
    x = rnd_in(); x.wreg = 1'b1; x.hilo_temp = 64'h00000001_00000002; x.cnt = 2'd1;
    apply(x, 6'b001000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || mem_wreg !== 1'b0 || mem_valid !== 1'b0 ||
        hilo_temp_o !== 64'h00000001_00000002 || cnt_o !== 2'd1) begin
      failures++; $display("FAIL bubble got=%h exp=%h", got, exp_v);
    end
    apply(rnd_in(), 6'b011000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || cnt_o !== 2'd1) begin
      failures++; $display("FAIL bubble_persist got=%h exp=%h", got, exp_v);
    end
    x = rnd_in(); x.valid = 1'b1;
    apply(x, 6'b000000, 1'b0);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || hilo_temp_o !== 64'h0 || cnt_o !== 2'd0) begin
      failures++; $display("FAIL bubble_release got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_hold();
    bundle_t x;
    x = rnd_in(); x.valid = 1'b1; x.wdata = 32'hA5A5A5A5;
    apply(x, 6'b000000, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      apply(rnd_in(), 6'b011000, 1'b0);
      got = dut_out(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v || mem_wdata !== 32'hA5A5A5A5) begin
        failures++; $display("FAIL hold_%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_flush();
    bundle_t x;
    x = rnd_in(); x.cnt = 2'd1;
    apply(x, 6'b001000, 1'b1);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || got !== bundle_t'(0) || cnt_o !== 2'd0) begin
      failures++; $display("FAIL flush_stall got=%h exp=%h", got, exp_v);
    end
    x = rnd_in(); x.wreg = 1'b1;
    apply(x, 6'b000000, 1'b0);
    void'(exp_q.pop_front());
    x = rnd_in(); x.wreg = 1'b1;
    apply(x, 6'b000000, 1'b1);
    got = dut_out(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v || mem_wreg !== 1'b0) begin
      failures++; $display("FAIL flush_advance got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    bundle_t x;
    for (int i = 0; i < 8; i++) begin
      x = rnd_in(); x.valid = 1'b1; x.wdata = 32'(i);
      apply(x, 6'b000000, 1'b0);
      got = dut_out(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v || mem_wdata !== 32'(i)) begin
        failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    #2;
    test_reset_mid_hold();
    test_advance();
    test_bubble_temps();
    test_hold();
    test_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
